// File: rtl/wbm_bridge_pkg.sv
// rtl/wbm_bridge_pkg.sv - shared types and constants for the Wishbone command bridge
package wbm_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] RSP_ERR_DATA = 32'h0;
  localparam int TXN_W = 16;
  localparam int ERR_W = 8;

endpackage

// File: rtl/wbm_stat_counters.sv
// rtl/wbm_stat_counters.sv - wrapping transaction counter and saturating error counter
module wbm_stat_counters
  import wbm_bridge_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             txn_inc,
  input  logic             err_inc,
  output logic [TXN_W-1:0] txn_count,
  output logic [ERR_W-1:0] err_count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_count <= '0;
      err_count <= '0;
    end else begin
      if (txn_inc) begin
        txn_count <= txn_count + TXN_W'(1);
      end
      // Error count sticks at all-ones so a long soak never hides failures.
      if (err_inc && (err_count != '1)) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: rtl/wbm_cmd_bridge.sv
// rtl/wbm_cmd_bridge.sv - single-command Wishbone classic master with timeout and stats
module wbm_cmd_bridge
  import wbm_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic [15:0] txn_count_o,
  output logic [7:0]  err_count_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            txn_inc;
  logic            err_inc;

  assign cmd_ready_o = (state == IDLE) && wb_rst_ni;
  assign to_hit      = (to_cnt == TO_LAST);
  // Ack beats the timeout threshold when both land on the same edge.
  assign txn_inc     = (state == BUS) && (wbm_ack_i || to_hit);
  assign err_inc     = (state == BUS) && !wbm_ack_i && to_hit;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      to_cnt      <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wbm_we_o  <= cmd_we_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            to_cnt    <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? RSP_ERR_DATA : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (to_hit) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= RSP_ERR_DATA;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  wbm_stat_counters u_stats (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .txn_inc   (txn_inc),
    .err_inc   (err_inc),
    .txn_count (txn_count_o),
    .err_count (err_count_o)
  );

endmodule

// File: tb/tb_wbm_cmd_bridge.sv
// tb/tb_wbm_cmd_bridge.sv - randomized and directed checks of wbm_cmd_bridge against a transaction model
module tb_wbm_cmd_bridge;

  localparam int T = 8;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [15:0] txn_count;
  logic [7:0]  err_count;

  logic        ack_drv;
  logic [31:0] dat_drv;
  logic        b2b;

  int n_cmp;
  int n_fail;
  int txn_exp;
  int err_exp;

  // In back-to-back mode the slave acks immediately and returns a function of the address.
  assign ack  = b2b ? (cyc & stb) : ack_drv;
  assign rdat = b2b ? (adr ^ 32'h5A5A_0000) : dat_drv;

  wbm_cmd_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_sel_o   (sel),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (wdat),
    .wbm_ack_i   (ack),
    .wbm_dat_i   (rdat),
    .txn_count_o (txn_count),
    .err_count_o (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_txn"}, 32'(txn_count), 32'(txn_exp & 'hFFFF));
    chk({tag, "_err"}, 32'(err_count), 32'(err_exp));
  endtask

  // One full command: ack_dly is the BUS cycle index (0-based) of the ack; >= T means no ack.
  task automatic do_txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                        input logic [3:0] t_sel, input int ack_dly, input logic [31:0] t_rd,
                        input int stall);
    bit          ok;
    int          exp_cyc;
    int          cyc_n;
    logic [31:0] exp_dat;
    ok      = (ack_dly < T);
    exp_cyc = ok ? ack_dly + 1 : T;
    exp_dat = (t_we || !ok) ? 32'h0 : t_rd;
    chk("ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_we = t_we; cmd_adr = t_adr; cmd_dat = t_dat; cmd_sel = t_sel;
    step();
    cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom;
    cmd_sel = 4'($urandom);
    chk("bus_stb", 32'(stb), 32'd1);
    chk("bus_we", 32'(we), 32'(t_we));
    chk("bus_sel", 32'(sel), 32'(t_sel));
    chk("bus_dat", wdat, t_dat);
    chk("ready_bus", 32'(cmd_ready), 32'd0);
    cyc_n = 0;
    for (int i = 0; i < T + 4; i++) begin
      if (!cyc) break;
      cyc_n++;
      chk("bus_adr", adr, t_adr);
      ack_drv = (i == ack_dly);
      dat_drv = (i == ack_dly) ? t_rd : $urandom;
      step();
    end
    ack_drv = 1'b0;
    chk("cyc_cycles", 32'(cyc_n), 32'(exp_cyc));
    txn_exp++;
    if (!ok && err_exp < 255) err_exp++;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(!ok));
    chk("rsp_dat", rsp_dat, exp_dat);
    chk("rsp_stb", 32'(stb), 32'd0);
    chk_counts("rsp");
    for (int s = 0; s < stall; s++) begin
      ack_drv = 1'($urandom);
      step();
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_dat", rsp_dat, exp_dat);
      chk("stall_err", 32'(rsp_err), 32'(!ok));
      chk("stall_cyc", 32'(cyc), 32'd0);
      chk("stall_ready", 32'(cmd_ready), 32'd0);
      chk_counts("stall");
    end
    ack_drv = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("done_valid", 32'(rsp_valid), 32'd0);
    chk("done_err", 32'(rsp_err), 32'd0);
    chk("done_dat_hold", rsp_dat, exp_dat);
    chk("done_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    int acc;
    int got;
    int last;
    int cnt;
    bit took;
    n_cmp = 0; n_fail = 0; txn_exp = 0; err_exp = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; ack_drv = 1'b0; dat_drv = '0; b2b = 1'b0;

    repeat (3) step();
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk_counts("rst");
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    do_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 1, 32'h1111_2222, 0);
    do_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 5);
    do_txn(1'b0, 32'h3000_0008, 32'h0, 4'h3, 99, 32'h0, 1);
    do_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, T - 1, 32'hCAFE_F00D, 0);

    ack_drv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dat_drv = $urandom;
      step();
      chk("idle_ack_cyc", 32'(cyc), 32'd0);
      chk("idle_ack_valid", 32'(rsp_valid), 32'd0);
      chk("idle_ack_ready", 32'(cmd_ready), 32'd1);
    end
    ack_drv = 1'b0;
    chk_counts("idle_ack");

    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, T + 1),
             $urandom, $urandom_range(0, 3));
    end

    for (int i = 0; i < 256; i++) begin
      do_txn(1'($urandom), $urandom, $urandom, 4'hF, T + 5, $urandom, 0);
    end
    chk("err_saturated", 32'(err_count), 32'hFF);

    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0010; cmd_sel = 4'hF;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("mid_bus_cyc", 32'(cyc), 32'd1);
    rst_n = 1'b0;
    step();
    txn_exp = 0; err_exp = 0;
    chk("midrst_cyc", 32'(cyc), 32'd0);
    chk("midrst_stb", 32'(stb), 32'd0);
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd0);
    chk_counts("midrst");
    ack_drv = 1'b1; dat_drv = 32'h0BAD_0BAD;
    rst_n = 1'b1;
    step();
    ack_drv = 1'b0;
    chk("late_ack_ready", 32'(cmd_ready), 32'd1);
    chk("late_ack_cyc", 32'(cyc), 32'd0);
    chk("late_ack_valid", 32'(rsp_valid), 32'd0);
    chk_counts("late_ack");

    b2b = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = $urandom;
    acc = 0; got = 0; last = -1; cnt = 0;
    while ((acc < 10 || got < 10) && cnt < 80) begin
      took = cmd_valid && cmd_ready;
      if (took) begin
        if (last >= 0) chk("b2b_gap", 32'(cnt - last), 32'd3);
        last = cnt;
        exp_q.push_back(cmd_adr ^ 32'h5A5A_0000);
        acc++;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("b2b_unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          chk("b2b_data", rsp_dat, exp_q.pop_front());
          chk("b2b_err", 32'(rsp_err), 32'd0);
        end
        got++;
        txn_exp++;
      end
      step();
      cnt++;
      if (took) cmd_adr = $urandom;
      if (acc == 10) cmd_valid = 1'b0;
    end
    chk("b2b_accepted", 32'(acc), 32'd10);
    chk("b2b_returned", 32'(got), 32'd10);
    b2b = 1'b0; rsp_ready = 1'b0;
    step();
    chk_counts("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
